// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam int          EXCCODE_W    = 5;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues SRAM-like bus requests and
// fills the decode slot with each accepted fetch or a misaligned-PC exception.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 inst_req,
  output logic [31:0]          inst_addr,
  input  logic                 inst_addr_ok,
  input  logic                 inst_data_ok,
  input  logic                 exc_redirect,
  input  logic [31:0]          exc_target,
  input  logic                 br_redirect,
  input  logic [31:0]          br_target,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [31:0]          pc_o,
  output logic                 cancelled_o,
  output logic                 exc_o,
  output logic [EXCCODE_W-1:0] exccode_o,
  output logic [31:0]          perfcnt_fetch_waitaddr
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic                 outstanding_q, outstanding_d;
  logic                 valid_q, valid_d;
  logic [31:0]          slot_pc_q, slot_pc_d;
  logic                 cancelled_q, cancelled_d;
  logic                 exc_q, exc_d;
  logic [EXCCODE_W-1:0] exccode_q, exccode_d;
  logic [31:0]          perf_q, perf_d;

  logic        adel;
  logic        fire;
  logic        redir;
  logic [31:0] redir_pc;

  always_comb begin
    adel     = (pc_q[1:0] != 2'b00);
    redir    = exc_redirect || br_redirect;
    redir_pc = exc_redirect ? exc_target : br_target;
    // Only one fetch in flight; the returning beat frees the slot the same cycle.
    inst_req = (state_q == ST_RUN) && ready_i && !adel &&
               !(outstanding_q && !inst_data_ok);
    fire     = inst_req && inst_addr_ok;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    valid_d       = valid_q;
    slot_pc_d     = slot_pc_q;
    cancelled_d   = cancelled_q;
    exc_d         = exc_q;
    exccode_d     = exccode_q;
    perf_d        = perf_q;

    if (fire && !inst_data_ok) begin
      outstanding_d = 1'b1;
    end else if (!fire && inst_data_ok) begin
      outstanding_d = 1'b0;
    end

    // A redirect wins even over an accepted request, which then goes wrong-path.
    if (redir) begin
      pc_d = redir_pc;
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end

    if (redir) begin
      state_d = ST_RUN;
    end

    if (ready_i) begin
      if (fire) begin
        valid_d     = 1'b1;
        slot_pc_d   = pc_q;
        exc_d       = 1'b0;
        cancelled_d = redir;
      end else if ((state_q == ST_RUN) && adel && !redir) begin
        valid_d     = 1'b1;
        slot_pc_d   = pc_q;
        exc_d       = 1'b1;
        exccode_d   = EXC_ADEL;
        cancelled_d = 1'b0;
        state_d     = ST_HALT;
      end else begin
        valid_d     = 1'b0;
        cancelled_d = 1'b0;
        exc_d       = 1'b0;
      end
    end else if (redir && valid_q && !exc_q) begin
      cancelled_d = 1'b1;
    end

    if (inst_req && !inst_addr_ok) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      valid_q       <= 1'b0;
      slot_pc_q     <= 32'd0;
      cancelled_q   <= 1'b0;
      exc_q         <= 1'b0;
      exccode_q     <= '0;
      perf_q        <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      valid_q       <= valid_d;
      slot_pc_q     <= slot_pc_d;
      cancelled_q   <= cancelled_d;
      exc_q         <= exc_d;
      exccode_q     <= exccode_d;
      perf_q        <= perf_d;
    end
  end

  assign inst_addr              = pc_q;
  assign valid_o                = valid_q;
  assign pc_o                   = slot_pc_q;
  assign cancelled_o            = cancelled_q;
  assign exc_o                  = exc_q;
  assign exccode_o              = exccode_q;
  assign perfcnt_fetch_waitaddr = perf_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stalls, redirects and ADEL halt.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        exc_redirect;
  logic [31:0] exc_target;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic        cancelled_o;
  logic        exc_o;
  logic [4:0]  exccode_o;
  logic [31:0] perfcnt_fetch_waitaddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .inst_req               (inst_req),
    .inst_addr              (inst_addr),
    .inst_addr_ok           (inst_addr_ok),
    .inst_data_ok           (inst_data_ok),
    .exc_redirect           (exc_redirect),
    .exc_target             (exc_target),
    .br_redirect            (br_redirect),
    .br_target              (br_target),
    .ready_i                (ready_i),
    .valid_o                (valid_o),
    .pc_o                   (pc_o),
    .cancelled_o            (cancelled_o),
    .exc_o                  (exc_o),
    .exccode_o              (exccode_o),
    .perfcnt_fetch_waitaddr (perfcnt_fetch_waitaddr)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic rdy, input logic aok, input logic dok,
                       input logic exr, input logic [31:0] ext,
                       input logic brr, input logic [31:0] brt);
    ready_i      = rdy;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    exc_redirect = exr;
    exc_target   = ext;
    br_redirect  = brr;
    br_target    = brt;
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                          input logic c, input logic e);
    chk_eq({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    chk_eq({tag, "_pc"}, pc_o, pc);
    chk_eq({tag, "_cancel"}, {31'd0, cancelled_o}, {31'd0, c});
    chk_eq({tag, "_exc"}, {31'd0, exc_o}, {31'd0, e});
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    chk_slot("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_eq("rst_exccode", {27'd0, exccode_o}, 32'd0);
    chk_eq("rst_perf", perfcnt_fetch_waitaddr, 32'd0);
    chk_eq("rst_addr", inst_addr, 32'hBFC00000);

    // First request waits three cycles for addr_ok.
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_eq("wait_req", {31'd0, inst_req}, 32'd1);
      chk_eq("wait_addr", inst_addr, 32'hBFC00000);
      tick();
      chk_eq("wait_valid", {31'd0, valid_o}, 32'd0);
      chk_eq("wait_perf", perfcnt_fetch_waitaddr, i + 1);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("acc_addr0", inst_addr, 32'hBFC00000);
    tick();
    chk_slot("f0", 1'b1, 32'hBFC00000, 1'b0, 1'b0);
    chk_eq("perf_after_acc", perfcnt_fetch_waitaddr, 32'd3);

    // Back-to-back issue on the data_ok cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("b2b_req", {31'd0, inst_req}, 32'd1);
    chk_eq("b2b_addr", inst_addr, 32'hBFC00004);
    tick();
    chk_slot("f1", 1'b1, 32'hBFC00004, 1'b0, 1'b0);

    // Branch redirect coinciding with acceptance of BFC00008.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h80001000);
    chk_eq("br_acc_addr", inst_addr, 32'hBFC00008);
    tick();
    chk_slot("f2", 1'b1, 32'hBFC00008, 1'b1, 1'b0);

    // One beat still outstanding and no data: must not issue a second request.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("one_inflight_req", {31'd0, inst_req}, 32'd0);
    tick();
    chk_eq("bubble_valid", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("br_tgt_addr", inst_addr, 32'h80001000);
    tick();
    chk_slot("f3", 1'b1, 32'h80001000, 1'b0, 1'b0);

    // Exception redirect beats a simultaneous branch redirect.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h80000180, 1'b1, 32'h80002000);
    chk_eq("prio_req", {31'd0, inst_req}, 32'd1);
    tick();
    chk_eq("prio_valid", {31'd0, valid_o}, 32'd0);
    chk_eq("prio_perf", perfcnt_fetch_waitaddr, 32'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("prio_addr", inst_addr, 32'h80000180);
    tick();
    chk_slot("f4", 1'b1, 32'h80000180, 1'b0, 1'b0);

    // Misaligned branch target: ADEL in the slot, then HALT.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h80000102);
    tick();
    chk_eq("adel_pre_valid", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("adel_req", {31'd0, inst_req}, 32'd0);
    chk_eq("adel_addr", inst_addr, 32'h80000102);
    tick();
    chk_slot("adel", 1'b1, 32'h80000102, 1'b0, 1'b1);
    chk_eq("adel_code", {27'd0, exccode_o}, 32'h4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("halt_req0", {31'd0, inst_req}, 32'd0);
    tick();
    chk_eq("halt_valid", {31'd0, valid_o}, 32'd0);
    chk_eq("halt_perf", perfcnt_fetch_waitaddr, 32'd5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80000180, 1'b0, 32'd0);
    chk_eq("halt_req1", {31'd0, inst_req}, 32'd0);
    tick();
    chk_eq("resume_valid", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("resume_req", {31'd0, inst_req}, 32'd1);
    chk_eq("resume_addr", inst_addr, 32'h80000180);
    tick();
    chk_slot("f5", 1'b1, 32'h80000180, 1'b0, 1'b0);

    // Decode stalls four cycles; data returns in stall 2, redirect in stall 3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, (i == 1), 1'b0, 32'd0, (i == 2), 32'h80003000);
      chk_eq("stall_req", {31'd0, inst_req}, 32'd0);
      tick();
      chk_slot("stall", 1'b1, 32'h80000180, (i >= 2), 1'b0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_eq("post_stall_req", {31'd0, inst_req}, 32'd1);
    chk_eq("post_stall_addr", inst_addr, 32'h80003000);
    tick();
    chk_slot("f6", 1'b1, 32'h80003000, 1'b0, 1'b0);
    chk_eq("final_perf", perfcnt_fetch_waitaddr, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
